fetch_stage: RTL and testbench

Instruction fetch stage of the RV32 core, sitting between the PC register and decode. Reads the current PC, fetches one instruction at a time from instruction memory over a valid/ready request and valid-only response interface, and holds the result in a registered output slot for decode. Drives the PC register's next-value input: hold, +4 or branch redirect. Allows at most one outstanding memory request.

---
 rtl/rv_fetch_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_slot.sv | 46 ++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port: valid/ready request, valid-only response.
interface fetch_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    modport master (output req_valid, addr, input req_ready, rsp_valid, rdata, rsp_err);
    modport slave  (input req_valid, addr, output req_ready, rsp_valid, rdata, rsp_err);
endinterface

// File: rtl/fetch_slot.sv
// Registered output entry towards decode; load wins over consume, clear wins over both.
module fetch_slot
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  fetch_entry_t entry_i,
    input  logic         clear_i,
    input  logic         ready_i,
    output logic         valid_o,
    output fetch_entry_t entry_o,
    output logic         slot_free_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (clear_i || (!load_i && valid_q && ready_i)) begin
            // An empty slot always presents a NOP with no fault.
            valid_d = 1'b0;
            entry_d = '{pc: entry_q.pc, instr: NOP_INSTR, fault: 1'b0};
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            entry_q <= '{pc: RESET_PC, instr: NOP_INSTR, fault: 1'b0};
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o     = valid_q;
    assign entry_o     = entry_q;
    assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: single-outstanding instruction fetch FSM and next-PC mux.
module fetch_stage
    import rv_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    output logic [31:0]   pc_next,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instr,
    output logic          if_fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         slot_free;
    logic         misaligned;
    logic         req_fire;
    logic         load;
    fetch_entry_t load_entry;
    fetch_entry_t slot_entry;

    assign misaligned     = (pc[1:0] != 2'b00);
    assign imem.req_valid = rst && (state_q == S_REQ) && slot_free && !redirect_valid && !misaligned;
    assign imem.addr      = pc;
    assign req_fire       = imem.req_valid && imem.req_ready;
    assign req_pc_d       = req_fire ? pc : req_pc_q;

    always_comb begin
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (req_fire) begin
            pc_next = pc + PC_STEP;
        end else begin
            pc_next = pc;
        end
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_entry = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
        unique case (state_q)
            S_REQ: begin
                if (!redirect_valid) begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end else if (misaligned && slot_free) begin
                        load = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem.rsp_valid) begin
                    state_d = S_REQ;
                    if (!redirect_valid) begin
                        load       = 1'b1;
                        load_entry = '{pc:    req_pc_q,
                                       instr: imem.rsp_err ? NOP_INSTR : imem.rdata,
                                       fault: imem.rsp_err};
                    end
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The stale response retires the drop even if another redirect lands with it.
                if (imem.rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_REQ;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .entry_i     (load_entry),
        .clear_i     (redirect_valid),
        .ready_i     (if_ready),
        .valid_o     (if_valid),
        .entry_o     (slot_entry),
        .slot_free_o (slot_free)
    );

    assign if_pc    = slot_entry.pc;
    assign if_instr = slot_entry.instr;
    assign if_fault = slot_entry.fault;

    a_no_rsp_in_req : assert property (@(posedge clk) disable iff (!rst)
        !((state_q == S_REQ) && imem.rsp_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a program-order fetch model with a latency-randomized memory.
module tb_fetch_stage;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    // PC register feeding the stage
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[5:2] == 4'h8);
    endfunction

    // stimulus knobs: mode 0 random, 1 high, 2 low
    int          ifr_mode = 0;
    int          rdy_mode = 0;
    int          lat_fix = 0;
    bit          rand_redir = 0;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = 32'h0;

    // reference model
    bit           m_valid = 0;
    fetch_entry_t m_ent;
    bit           m_out = 0;
    bit           m_live = 0;
    int           m_cnt = 0;
    logic [31:0]  m_addr = 32'h0;
    logic [31:0]  prog_pc = RESET_PC;
    bit           steady = 0;
    int           cyc = 0;
    int           last_load = -1;
    bit           prev_pend = 0;
    logic [31:0]  prev_addr = 32'h0;
    logic [31:0]  obs_pc_next;
    logic         obs_rv;
    logic [31:0]  obs_addr;

    task automatic step();
        logic         slot_free;
        logic         exp_rv;
        logic         load;
        logic [31:0]  exp_nx;
        fetch_entry_t nent;

        check_eq("if_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("if_pc", if_pc, m_ent.pc);
            check_eq("if_instr", if_instr, m_ent.instr);
            check_eq("if_fault", 32'(if_fault), 32'(m_ent.fault));
        end

        if_ready           = (ifr_mode == 0) ? ($urandom_range(0, 3) != 0) : (ifr_mode == 1);
        imem_bus.req_ready = (rdy_mode == 0) ? ($urandom_range(0, 9) < 7) : (rdy_mode == 1);
        redirect_valid = 1'b0;
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_req      = 0;
        end else if (rand_redir && $urandom_range(0, 31) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        end
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rdata     = 32'h0;
        imem_bus.rsp_err   = 1'b0;
        if (m_out) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_bus.rsp_valid = 1'b1;
                imem_bus.rdata     = mem_word(m_addr);
                imem_bus.rsp_err   = mem_err(m_addr);
            end
        end
        #1;

        slot_free = !m_valid || if_ready;
        exp_rv    = !m_out && slot_free && !redirect_valid && (pc[1:0] == 2'b00);
        check_eq("req_valid", 32'(imem_bus.req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("imem_addr", imem_bus.addr, pc);
        if (prev_pend && !redirect_valid) begin
            check_eq("hold_valid", 32'(imem_bus.req_valid), 32'd1);
            check_eq("hold_addr", imem_bus.addr, prev_addr);
        end
        exp_nx = redirect_valid ? redirect_pc :
                 (exp_rv && imem_bus.req_ready) ? pc + 32'd4 : pc;
        check_eq("pc_next", pc_next, exp_nx);
        obs_pc_next = pc_next;
        obs_rv      = imem_bus.req_valid;
        obs_addr    = imem_bus.addr;
        prev_pend   = exp_rv && !imem_bus.req_ready && !m_valid;
        prev_addr   = pc;

        load = 1'b0;
        nent = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};
        if (redirect_valid) begin
            m_valid = 0;
            prog_pc = redirect_pc;
        end else if (m_out && imem_bus.rsp_valid && m_live) begin
            load = 1'b1;
            nent = '{pc: m_addr, instr: mem_err(m_addr) ? NOP_INSTR : mem_word(m_addr),
                     fault: mem_err(m_addr)};
        end else if (!m_out && pc[1:0] != 2'b00 && slot_free) begin
            load = 1'b1;
            nent = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
        end else if (m_valid && if_ready) begin
            m_valid = 0;
        end
        if (load) begin
            check_eq("prog_order", nent.pc, prog_pc);
            if (nent.pc[1:0] == 2'b00) prog_pc = prog_pc + 32'd4;
            if (steady && last_load >= 0) check_eq("load_gap", 32'(cyc - last_load), 32'd2);
            last_load = cyc;
            m_valid   = 1;
            m_ent     = nent;
        end

        if (imem_bus.rsp_valid) m_out = 0;
        if (imem_bus.req_valid && imem_bus.req_ready) begin
            m_out  = 1;
            m_live = 1;
            m_addr = pc;
            m_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
        end
        if (redirect_valid) m_live = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic go_idle();
        rand_redir = 0;
        rdy_mode   = 2;
        repeat (4) step();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir_req = 1;
        redir_tgt = tgt;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_ready           = 1'b1;
        imem_bus.req_ready = 1'b1;
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rdata     = 32'h0;
        imem_bus.rsp_err   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", if_pc, RESET_PC);
        check_eq("rst_if_instr", if_instr, NOP_INSTR);
        check_eq("rst_if_fault", 32'(if_fault), 32'd0);
        check_eq("rst_req_valid", 32'(imem_bus.req_valid), 32'd0);
        rst = 1'b1;

        // back-to-back fetch from reset, latency 1, decode always ready
        ifr_mode = 1; rdy_mode = 1; lat_fix = 1; steady = 1;
        repeat (24) step();
        steady = 0;

        // decode stall holding the entry at 0x8
        go_idle();
        rdy_mode = 1; ifr_mode = 2; lat_fix = 1;
        redirect_to(32'h8);
        repeat (2) step();
        repeat (5) begin
            step();
            check_eq("stall_no_req", 32'(obs_rv), 32'd0);
            check_eq("stall_pc_next", obs_pc_next, 32'hC);
        end
        check_eq("stall_entry_pc", if_pc, 32'h8);
        ifr_mode = 1;
        step();
        check_eq("stall_resume_req", 32'(obs_rv), 32'd1);
        check_eq("stall_resume_addr", obs_addr, 32'hC);

        // redirect while a request is outstanding
        go_idle();
        rdy_mode = 1; ifr_mode = 1; lat_fix = 3;
        redirect_to(32'h10);
        step();
        redirect_to(32'h100);
        repeat (2) step();
        step();
        check_eq("drop_no_entry", 32'(if_valid), 32'd0);
        check_eq("drop_next_addr", obs_addr, 32'h100);
        check_eq("drop_next_req", 32'(obs_rv), 32'd1);

        // redirect coincident with the response
        go_idle();
        rdy_mode = 1; ifr_mode = 1; lat_fix = 2;
        redirect_to(32'h200);
        repeat (2) step();
        redirect_to(32'h300);
        check_eq("coinc_no_entry", 32'(if_valid), 32'd0);
        step();
        check_eq("coinc_next_req", 32'(obs_rv), 32'd1);
        check_eq("coinc_next_addr", obs_addr, 32'h300);

        // misaligned redirect target gives a fault entry without touching memory
        go_idle();
        ifr_mode = 2; rdy_mode = 1; lat_fix = 1;
        redirect_to(32'h102);
        step();
        check_eq("mis_no_req", 32'(obs_rv), 32'd0);
        check_eq("mis_if_pc", if_pc, 32'h102);
        check_eq("mis_if_fault", 32'(if_fault), 32'd1);
        check_eq("mis_if_instr", if_instr, NOP_INSTR);
        ifr_mode = 1;
        repeat (2) step();
        redirect_to(32'h40);
        repeat (4) step();

        // wrap at the top of the address space under memory backpressure
        go_idle();
        ifr_mode = 1; rdy_mode = 2; lat_fix = 1;
        redirect_to(32'hFFFF_FFFC);
        repeat (3) begin
            step();
            check_eq("wrap_hold_valid", 32'(obs_rv), 32'd1);
            check_eq("wrap_hold_addr", obs_addr, 32'hFFFF_FFFC);
        end
        rdy_mode = 1;
        step();
        check_eq("wrap_pc_next", obs_pc_next, 32'h0);
        repeat (4) step();

        // randomized traffic
        ifr_mode = 0; rdy_mode = 0; lat_fix = 0; rand_redir = 1;
        repeat (3000) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
